// File: rtl/dmem_ctrl_pkg.sv
// Shared FSM encodings, bus levels and constants for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic        RAM_WRITE  = 1'b1;
    localparam logic        RAM_READ   = 1'b0;
    localparam logic        RAM_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic word_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/acknowledge bus between the data-memory controller (master) and memory (slave).
interface dmem_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dmem_ctrl_rdbuf.sv
// One-entry load buffer (valid, word tag, data); only instantiated when DMEM_RDBUF_EN is defined.
module dmem_rdbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_tag,
    input  logic        fill_en,
    input  logic [29:0] fill_tag,
    input  logic [31:0] fill_data,
    input  logic        clr,
    output logic        hit,
    output logic [31:0] data
);

    logic        valid_reg;
    logic [29:0] tag_reg;
    logic [31:0] data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end else if (fill_en) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_tag;
            data_reg  <= fill_data;
        end
    end

    assign hit  = valid_reg && (tag_reg == lookup_tag);
    assign data = data_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns pipeline loads/stores into req/ack bus cycles with timeout.
// Define DMEM_RDBUF_EN to add a one-entry load buffer that answers repeated loads without the bus.
import dmem_ctrl_pkg::*;

module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    input  logic        flush,
    output logic [31:0] rdData,
    output logic        stall_req,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    dmem_ctrl_if.master bus
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [7:0]  cnt_inc;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rd_reg;
    logic        we_reg;
    logic        err_reg;

    logic        req_ok;
    logic        aligned;
    logic        access;
    logic        buf_hit;
    logic [31:0] buf_data;
    logic        tmo;

    assign req_ok  = (memCe == RAM_ENABLE) && !flush;
    assign aligned = word_aligned(memAddr[1:0]);
    assign cnt_inc = cnt_reg + 8'd1;
    assign tmo     = (state_reg == BUSY) && !bus.bus_ack && (cnt_inc == TMO_LIMIT);

`ifdef DMEM_RDBUF_EN
    logic buf_match;
    logic buf_fill;
    logic buf_clr;

    // Stores may alias the buffered word and a timed-out load leaves it untrustworthy.
    assign buf_fill = (state_reg == BUSY) && bus.bus_ack && (we_reg == RAM_READ);
    assign buf_clr  = (access && (memWr == RAM_WRITE)) || tmo;

    dmem_rdbuf u_rdbuf (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (memAddr[31:2]),
        .fill_en    (buf_fill),
        .fill_tag   (addr_reg[31:2]),
        .fill_data  (bus.bus_rdata),
        .clr        (buf_clr),
        .hit        (buf_match),
        .data       (buf_data)
    );

    assign buf_hit = (state_reg == IDLE) && req_ok && aligned && (memWr == RAM_READ) && buf_match;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = ZERO_WORD;
`endif

    assign access = (state_reg == IDLE) && req_ok && aligned && !buf_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            rd_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= tmo;
            if (access) begin
                addr_reg  <= memAddr;
                wdata_reg <= wtData;
                we_reg    <= memWr;
                cnt_reg   <= '0;
            end else if (state_reg == BUSY) begin
                if (bus.bus_ack) begin
                    rd_reg <= (we_reg == RAM_WRITE) ? ZERO_WORD : bus.bus_rdata;
                end else if (tmo) begin
                    rd_reg <= ZERO_WORD;
                end else begin
                    cnt_reg <= cnt_inc;
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        stall_req   = 1'b0;
        bus.bus_req = 1'b0;
        adel        = 1'b0;
        ades        = 1'b0;
        rdData      = ZERO_WORD;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    state_next = BUSY;
                    stall_req  = 1'b1;
                end
                if (req_ok && !aligned) begin
                    adel = (memWr == RAM_READ);
                    ades = (memWr == RAM_WRITE);
                end
                if (buf_hit) begin
                    rdData = buf_data;
                end
            end
            BUSY: begin
                bus.bus_req = 1'b1;
                stall_req   = 1'b1;
                if (bus.bus_ack || tmo) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rdData     = rd_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Outputs that depend on live pipeline inputs must stay quiet while reset is held.
        if (!rst) begin
            stall_req   = 1'b0;
            bus.bus_req = 1'b0;
            adel        = 1'b0;
            ades        = 1'b0;
            rdData      = ZERO_WORD;
        end
    end

    assign bus.bus_we    = we_reg;
    assign bus.bus_addr  = addr_reg;
    assign bus.bus_wdata = wdata_reg;
    assign bus_err       = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (TIMEOUT=4); also covers the DMEM_RDBUF_EN build when defined.
module tb_dmem_ctrl;

    typedef struct packed {
        logic [31:0] rd;
        logic [7:0]  stall;
        logic [7:0]  bus_cycles;
        logic [3:0]  err_cnt;
        logic        adel;
        logic        ades;
        logic        bus_ok;
        logic        after_req;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        mem_ce;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] wt_data;
    logic        flush;
    logic [31:0] rd_data;
    logic        stall_req;
    logic        adel;
    logic        ades;
    logic        bus_err;

    int          vec_cnt;
    int          miss_cnt;
    int          ack_after;
    int          busy_cnt;
    logic        force_ack;
    logic [31:0] resp_data;

    obs_t        exp_q[$];
    string       name_q[$];

    dmem_ctrl_if bus_if ();

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .memCe     (mem_ce),
        .memWr     (mem_wr),
        .memAddr   (mem_addr),
        .wtData    (wt_data),
        .flush     (flush),
        .rdData    (rd_data),
        .stall_req (stall_req),
        .adel      (adel),
        .ades      (ades),
        .bus_err   (bus_err),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks on the ack_after-th BUSY cycle (0 = never); force_ack injects stray acks.
    always @(posedge clk) begin
        #1;
        if (bus_if.bus_req) busy_cnt = busy_cnt + 1;
        else                busy_cnt = 0;
        bus_if.bus_ack   = force_ack || (bus_if.bus_req && ack_after != 0 && busy_cnt == ack_after);
        bus_if.bus_rdata = resp_data;
    end

    function automatic obs_t mk(input logic [31:0] rd, input int stall, input int bus_n,
                                input int err_n, input logic ad_l, input logic ad_s);
        obs_t e;
        e.rd         = rd;
        e.stall      = 8'(stall);
        e.bus_cycles = 8'(bus_n);
        e.err_cnt    = 4'(err_n);
        e.adel       = ad_l;
        e.ades       = ad_s;
        e.bus_ok     = 1'b1;
        e.after_req  = 1'b0;
        return e;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rd=%h stall=%0d bus=%0d err=%0d adel=%b ades=%b bus_ok=%b after_req=%b",
                         o.rd, o.stall, o.bus_cycles, o.err_cnt, o.adel, o.ades, o.bus_ok, o.after_req);
    endfunction

    // Drives one pipeline access starting at posedge+1, observes until the first non-stalled cycle,
    // then drops memCe and samples one more cycle; returns at posedge+1.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_n, input logic [31:0] rdata, output obs_t o);
        bit done;
        o = '0;
        o.bus_ok  = 1'b1;
        ack_after = ack_n;
        resp_data = rdata;
        mem_ce    = 1'b1;
        mem_wr    = we;
        mem_addr  = addr;
        wt_data   = wdata;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                o.adel = adel;
                o.ades = ades;
            end
            if (bus_if.bus_req === 1'b1) begin
                o.bus_cycles = o.bus_cycles + 8'd1;
                if (bus_if.bus_we !== we || bus_if.bus_addr !== addr || bus_if.bus_wdata !== wdata)
                    o.bus_ok = 1'b0;
            end
            if (bus_err === 1'b1) o.err_cnt = o.err_cnt + 4'd1;
            if (stall_req === 1'b1) o.stall = o.stall + 8'd1;
            else begin
                o.rd = rd_data;
                done = 1'b1;
            end
        end
        if (!done) o.stall = 8'hFF;
        @(posedge clk); #1;
        mem_ce = 1'b0;
        @(negedge clk);
        o.after_req = (bus_if.bus_req !== 1'b0);
        if (bus_err === 1'b1) o.err_cnt = o.err_cnt + 4'd1;
        @(posedge clk); #1;
        ack_after = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ce = 1'b1; mem_wr = 1'b0; mem_addr = 32'h10; wt_data = 32'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({stall_req, bus_if.bus_req, bus_if.bus_we, adel, ades, bus_err} !== 6'b0 || rd_data !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset_aligned: stall=%b req=%b we=%b adel=%b ades=%b err=%b rd=%h, required all 0",
                     stall_req, bus_if.bus_req, bus_if.bus_we, adel, ades, bus_err, rd_data);
        end
        mem_addr = 32'h13;
        #1;
        vec_cnt++;
        if ({stall_req, adel, ades} !== 3'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset_misaligned: stall=%b adel=%b ades=%b addr=%h wdata=%h, required all 0",
                     stall_req, adel, ades, bus_if.bus_addr, bus_if.bus_wdata);
        end
        @(posedge clk); #1;
        mem_ce = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_store();
        obs_t o, e;
        exp_q.push_back(mk(32'hDEAD_BEEF, 4, 3, 0, 1'b0, 1'b0)); name_q.push_back("load_0x10");
        do_access(1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL %s: got %s required %s", name_q.pop_front(), fmt(o), fmt(e)); end
        else void'(name_q.pop_front());

        exp_q.push_back(mk(32'h0, 3, 2, 0, 1'b0, 1'b0)); name_q.push_back("store_0x20");
        do_access(1'b1, 32'h20, 32'h1234_5678, 2, 32'h0, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL %s: got %s required %s", name_q.pop_front(), fmt(o), fmt(e)); end
        else void'(name_q.pop_front());
    endtask

    task automatic test_misaligned();
        obs_t o, e;
        logic [31:0] addrs [3] = '{32'h13, 32'h22, 32'h41};
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(32'h0, 0, 0, 0, !wes[i], wes[i]));
            do_access(wes[i], addrs[i], 32'hCAFE_0000, 1, 32'h5555_5555, o);
            e = exp_q.pop_front();
            vec_cnt++;
            if (o !== e) begin
                miss_cnt++;
                $display("FAIL misaligned_%h: got %s required %s", addrs[i], fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_flush();
        obs_t o, e;
        flush = 1'b1;
        exp_q.push_back(mk(32'h0, 0, 0, 0, 1'b0, 1'b0));
        do_access(1'b0, 32'h10, 32'h0, 1, 32'h7777_7777, o);
        flush = 1'b0;
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL flush_load: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        obs_t o[4], e;
        logic [31:0] addrs [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        logic [31:0] data  [4];
        int          lat   [4] = '{1, 2, 1, 3};
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            exp_q.push_back(mk(data[i], lat[i] + 1, lat[i], 0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 4; i++) do_access(1'b0, addrs[i], 32'h0, lat[i], data[i], o[i]);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (o[i] !== e) begin
                miss_cnt++;
                $display("FAIL b2b_load_%h: got %s required %s", addrs[i], fmt(o[i]), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        exp_q.push_back(mk(32'h0, 5, 4, 1, 1'b0, 1'b0));
        do_access(1'b0, 32'h200, 32'h0, 0, 32'hFFFF_FFFF, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL timeout_load: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_rdbuf();
        obs_t o, e;
        exp_q.push_back(mk(32'hA5A5_A5A5, 2, 1, 0, 1'b0, 1'b0));
        do_access(1'b0, 32'h40, 32'h0, 1, 32'hA5A5_A5A5, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL buf_fill_load: got %s required %s", fmt(o), fmt(e)); end
`ifdef DMEM_RDBUF_EN
        exp_q.push_back(mk(32'hA5A5_A5A5, 0, 0, 0, 1'b0, 1'b0));
`else
        exp_q.push_back(mk(32'h5A5A_0001, 2, 1, 0, 1'b0, 1'b0));
`endif
        do_access(1'b0, 32'h40, 32'h0, 1, 32'h5A5A_0001, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL buf_repeat_load: got %s required %s", fmt(o), fmt(e)); end

        exp_q.push_back(mk(32'h0, 2, 1, 0, 1'b0, 1'b0));
        do_access(1'b1, 32'h80, 32'h0BAD_0BAD, 1, 32'h0, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL buf_store_0x80: got %s required %s", fmt(o), fmt(e)); end

        exp_q.push_back(mk(32'h3C3C_3C3C, 2, 1, 0, 1'b0, 1'b0));
        do_access(1'b0, 32'h40, 32'h0, 1, 32'h3C3C_3C3C, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL buf_after_store: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_reset_mid_busy();
        obs_t o, e;
        ack_after = 0; mem_ce = 1'b1; mem_wr = 1'b0; mem_addr = 32'h300;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (bus_if.bus_req !== 1'b1 || stall_req !== 1'b1) begin
            miss_cnt++;
            $display("FAIL midrst_busy: req=%b stall=%b, required 1 1", bus_if.bus_req, stall_req);
        end
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if (bus_if.bus_req !== 1'b0 || stall_req !== 1'b0) begin
            miss_cnt++;
            $display("FAIL midrst_drop: req=%b stall=%b, required 0 0", bus_if.bus_req, stall_req);
        end
        mem_ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        force_ack = 1'b1; resp_data = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) force_ack = 1'b0;
            vec_cnt++;
            if (bus_if.bus_req !== 1'b0 || stall_req !== 1'b0 || rd_data !== 32'h0) begin
                miss_cnt++;
                $display("FAIL midrst_late_ack_%0d: req=%b stall=%b rd=%h, required 0 0 0",
                         i, bus_if.bus_req, stall_req, rd_data);
            end
        end
        @(posedge clk); #1;
        exp_q.push_back(mk(32'h600D_F00D, 3, 2, 0, 1'b0, 1'b0));
        do_access(1'b0, 32'h304, 32'h0, 2, 32'h600D_F00D, o);
        e = exp_q.pop_front();
        vec_cnt++;
        if (o !== e) begin miss_cnt++; $display("FAIL midrst_recover: got %s required %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        vec_cnt = 0; miss_cnt = 0;
        ack_after = 0; busy_cnt = 0; force_ack = 1'b0; resp_data = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        test_reset();
        test_load_store();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_rdbuf();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles to wait for bus_ack (8-bit counter).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous reset, active-low.
REQ-003 SHALL have pipeline-side ports: memCe in 1; memWr in 1 (1=store); memAddr in 32; wtData in 32; flush in 1 (exception flush); rdData out 32 (load data returned to the memory stage); stall_req out 1 (pipeline hold request).
REQ-004 SHALL have exception ports: adel out 1 (misaligned load); ades out 1 (misaligned store); bus_err out 1 (timeout).
REQ-005 SHALL have bus-side ports: bus_req out 1; bus_we out 1; bus_addr out 32; bus_wdata out 32; bus_ack in 1; bus_rdata in 32.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-007 IDLE: access = memCe && !flush && memAddr[1:0]==2'b00; on access, SHALL latch addr/wdata/we, assert stall_req combinationally in the same cycle, and enter BUSY.
REQ-008 Misaligned access in IDLE (memCe && !flush && memAddr[1:0]!=0) SHALL produce no bus activity, keep stall_req=0, and drive adel=!memWr or ades=memWr combinationally for that cycle.
REQ-009 BUSY: bus_req=1, with bus_we/bus_addr/bus_wdata driven from the latched registers and held stable until bus_ack; stall_req=1.
REQ-010 BUSY with bus_ack=1: SHALL capture bus_rdata (loads) into rd_q, drop bus_req on the next edge, and enter DONE; minimum latency is memCe to DONE in 2 cycles.
REQ-011 BUSY: a counter SHALL increment every cycle without ack; at count==TIMEOUT it SHALL drop bus_req, pulse bus_err for one cycle, set rd_q=0, and enter DONE.
REQ-012 DONE: stall_req=0, rdData=rd_q, lasting exactly one cycle, then IDLE; memCe still high in DONE SHALL NOT start a new access.
REQ-013 rdData SHALL be 0 whenever the state is not DONE and no buffer hit (REQ-019) occurs.
REQ-014 flush SHALL only suppress starting in IDLE; a transaction already in BUSY SHALL complete normally (no bus abort).
REQ-015 bus_ack outside BUSY SHALL be ignored.

Reset
REQ-016 With rst low, the FSM SHALL be IDLE, the counter 0, rd_q 0, the latches 0, and all outputs 0 (including stall_req, bus_req, adel, ades, bus_err).
REQ-017 Reset asserted mid-BUSY SHALL immediately drop bus_req and stall_req and discard the transaction.

Configuration
REQ-018 Macro DMEM_RDBUF_EN SHALL compile in a one-entry load buffer (valid, tag[31:2], data).
REQ-019 With the macro defined, an aligned load in IDLE with valid && tag==memAddr[31:2] SHALL be a hit: no bus access, stall_req=0, and rdData=buffer data in the same cycle.
REQ-020 With the macro defined, every completed bus load SHALL fill the buffer; any store start or bus_err SHALL clear valid; reset SHALL clear valid.
REQ-021 Without the macro, every aligned access SHALL go to the bus and no buffer state SHALL exist.

Structure
REQ-022 FSM state encodings, RamWrite/RamEnable levels, and Zero SHALL live in the shared define.v.
REQ-023 The load buffer SHALL be sub-module dmem_rdbuf, instantiated only under DMEM_RDBUF_EN.

Verification
REQ-024 Load 0x0000_0010, bus_ack after 3 BUSY cycles with bus_rdata=0xDEAD_BEEF -> stall_req high 4 cycles, then DONE with rdData=0xDEAD_BEEF and stall_req=0.
REQ-025 Store 0x0000_0020 with wtData=0x1234_5678 -> bus_we=1, bus_addr=0x20, bus_wdata=0x1234_5678 held until ack; then DONE.
REQ-026 Load 0x0000_0013 -> adel=1 in that cycle, bus_req stays 0, stall_req=0; store 0x0000_0022 -> ades=1.
REQ-027 TIMEOUT=4 with bus_ack never asserted -> bus_err pulses once after 4 BUSY cycles, bus_req drops, and DONE has rdData=0.
REQ-028 DMEM_RDBUF_EN: load 0x40 (bus returns 0xA5A5_A5A5), then load 0x40 again -> second load returns 0xA5A5_A5A5 with no bus_req; a store to 0x80 followed by load 0x40 -> bus access occurs.
REQ-029 rst driven low during BUSY -> bus_req=0 and stall_req=0 immediately; after rst is released, the state is IDLE and a late bus_ack is ignored.
